// File: rtl/poly_arith_stream.sv
// poly_arith_stream: streaming coefficient-wise modular ADD/SUB/RSUB/COPY over
// two operand RAMs with in-place write-back. One coefficient issued per enabled
// cycle; fixed 2-cycle read-to-write latency that never stalls in-flight data.
module poly_arith_stream #(
    parameter int N  = 512,
    parameter int Q  = 12289,
    parameter int DW = 16,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic [1:0]    op,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] ram_doa,
    input  logic [DW-1:0] ram_dob,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_RSUB = 2'b10;

    localparam logic [AW-1:0]      LAST_ADDR = AW'(N - 1);
    localparam logic signed [DW:0] Q_S       = (DW+1)'(Q);

    // Fold a raw DW+1-bit sum/difference back into [0,Q) with one correction.
    function automatic logic [DW-1:0] mod_correct(input logic [1:0] opc,
                                                  input logic signed [DW:0] raw);
        logic signed [DW:0] res;
        res = raw;
        case (opc)
            OP_ADD:          if (raw >= Q_S) res = raw - Q_S;
            OP_SUB, OP_RSUB: if (raw[DW]) res = raw + Q_S;
            default:         res = raw;
        endcase
        return res[DW-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            issue_p0;

    logic            vld_p1_q;
    logic [AW-1:0]   addr_p1_q;
    logic signed [DW:0] a_p1, b_p1, raw_p1;

    logic            vld_p2_q;
    logic [AW-1:0]   addr_p2_q;
    logic [DW-1:0]   data_p2_q;

    // P0: read issue, one address per enabled RUN cycle
    assign issue_p0 = (state_q == RUN) && en;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_en   = issue_p0;
    assign rd_addr = cnt_q;

    // Next-state logic: run sequencing, op latch and issue counter
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (issue_p0) begin
                    if (cnt_q == LAST_ADDR) state_d = DRAIN;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (vld_p2_q && (addr_p2_q == LAST_ADDR)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // P1: RAM data arrives; raw sum/difference against the registered address tag
    assign a_p1 = $signed({1'b0, ram_doa});
    assign b_p1 = $signed({1'b0, ram_dob});

    // Raw operation on widened operands, selected by the latched op
    always_comb begin
        raw_p1 = a_p1;
        case (op_q)
            OP_ADD:  raw_p1 = a_p1 + b_p1;
            OP_SUB:  raw_p1 = a_p1 - b_p1;
            OP_RSUB: raw_p1 = b_p1 - a_p1;
            default: raw_p1 = a_p1;
        endcase
    end

    // Address tag and valid travel with the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            addr_p1_q <= '0;
        end else begin
            vld_p1_q  <= issue_p0;
            addr_p1_q <= cnt_q;
        end
    end

    // P2: conditional correction registered onto the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            addr_p2_q <= '0;
            data_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                addr_p2_q <= addr_p1_q;
                data_p2_q <= mod_correct(op_q, raw_p1);
            end
        end
    end

    assign wr_en   = vld_p2_q;
    assign wr_addr = addr_p2_q;
    assign wr_data = data_p2_q;

endmodule
